fetch_front: RTL and testbench
==============================

Name: fetch_front

Overview:
- Front-end fetch pipeline: control (C), fetch-1 (F1) and fetch-2 (F2) stages feeding decode.
- C holds the fetch PC, picks the next PC (resteer priority, return stack) and emits the even/odd cache-line counters.
- F1 registers the line addresses presented to the external instruction cache.
- F2 captures the returned lines and extracts one 32-bit instruction per cycle with its PC.

Parameters:
XLEN, 32, address/instruction width
CL_SIZE, 128, cache line size in bits (16 bytes)
CLC_WIDTH, 28, line counter width = XLEN - log2(CL_SIZE/8)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
stall_in  in  1  downstream stall; freezes all stages
mem_stall  in  1  I-cache busy; freezes C and F1, bubbles F2
resteer  in  1  flush F1/F2 without redirect
resteer_taken_ROB  in  1  exception redirect
resteer_target_ROB  in  XLEN  exception target
resteer_taken_BR  in  1  mispredict redirect
resteer_target_BR  in  XLEN  mispredict target
resteer_taken_D1  in  1  decode redirect
resteer_target_D1  in  XLEN  decode target
ras_push  in  1  push ras_ret_addr
ras_pop  in  1  pop; pops with ras_valid_out=1 redirect fetch to top
ras_ret_addr  in  XLEN  return address
clc_even  out  CLC_WIDTH  even line counter
clc_odd  out  CLC_WIDTH  odd line counter
ras_data_out  out  XLEN  RAS top
ras_valid_out  out  1  RAS non-empty
addr_even  out  XLEN  F1 even line byte address
addr_odd  out  XLEN  F1 odd line byte address
addr_even_valid  out  1  F1 even valid
addr_odd_valid  out  1  F1 odd valid
cl_even  in  CL_SIZE  even line data
cl_odd  in  CL_SIZE  odd line data
hit_even  in  1  even line hit
hit_odd  in  1  odd line hit
IBuff_out  out  XLEN  fetched instruction
pc_out  out  XLEN  PC of IBuff_out
valid_out  out  1  IBuff_out valid

Behaviour:
- Reset: pc=0, RAS empty, all F1/F2 regs and valids 0, IBuff_out=0, pc_out=0.
- Next PC priority: ROB > BR > D1 > RAS pop (valid) > stall_in|mem_stall hold > pc+4. Targets loaded with bits [1:0] cleared. Redirects win over stalls.
- Line L = pc[XLEN-1:4]. L even: clc_even=L, clc_odd=L+1; L odd: clc_odd=L, clc_even=L+1 (modulo 2^CLC_WIDTH). Combinational from pc.
- RAS: 8 entries, circular. Push on full overwrites oldest. Pop on empty ignored. Push+pop same cycle replaces top (count unchanged). Not flushed by redirects.
- F1 (1 cycle after C): addr_even={clc_even,4'b0}, addr_odd={clc_odd,4'b0}, carries pc. Holds on stall_in|mem_stall. Valids=1 when loaded; cleared on any redirect or resteer.
- Cache assumed combinational on F1 addresses.
- F2 (1 cycle after F1):
  - Selects cl_even if F1 pc line LSB=0, else cl_odd.
  - Word w=pc[3:2]; data bits [32w+31:32w].
  - valid_out=F1 valid & selected hit & !mem_stall.
  - Holds on stall_in.
  - Cleared on redirect/resteer.
- First valid_out at cycle 2 after reset release.
- resteer alone: flush F1/F2 valids, pc unchanged.

Test Plan:
- Reset release, all hits, cl_even word0=0x00000013 -> valid_out at cycle 2, IBuff_out=0x00000013, pc_out=0; then pc_out 4, 8, 12 on consecutive cycles.
- pc=0x10 (line 1) -> clc_odd=1, clc_even=2; F2 selects cl_odd.
- BR and ROB taken same cycle, targets 0x100/0x200 -> next pc=0x200, valid_out 0 for 2 cycles, then pc_out=0x200.
- stall_in high 3 cycles -> all outputs frozen. mem_stall -> valid_out=0, pc/F1 held.
- Push 0xA0, 0xB0, pop -> redirect to 0xB0, ras_data_out=0xA0. 9 pushes -> oldest lost. Pop on empty -> no redirect.
- Hit on selected line deasserted -> valid_out=0.

Source files
------------

// File: rtl/fetch_front.sv
// Three-stage instruction fetch front end: C (next-PC select, return stack, line counters),
// F1 (I-cache line addresses) and F2 (line capture and 32-bit word extraction).
module fetch_front #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CL_SIZE   = 128,
  parameter int unsigned CLC_WIDTH = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_in,
  input  logic                 mem_stall,
  input  logic                 resteer,
  input  logic                 resteer_taken_ROB,
  input  logic [XLEN-1:0]      resteer_target_ROB,
  input  logic                 resteer_taken_BR,
  input  logic [XLEN-1:0]      resteer_target_BR,
  input  logic                 resteer_taken_D1,
  input  logic [XLEN-1:0]      resteer_target_D1,
  input  logic                 ras_push,
  input  logic                 ras_pop,
  input  logic [XLEN-1:0]      ras_ret_addr,
  output logic [CLC_WIDTH-1:0] clc_even,
  output logic [CLC_WIDTH-1:0] clc_odd,
  output logic [XLEN-1:0]      ras_data_out,
  output logic                 ras_valid_out,
  output logic [XLEN-1:0]      addr_even,
  output logic [XLEN-1:0]      addr_odd,
  output logic                 addr_even_valid,
  output logic                 addr_odd_valid,
  input  logic [CL_SIZE-1:0]   cl_even,
  input  logic [CL_SIZE-1:0]   cl_odd,
  input  logic                 hit_even,
  input  logic                 hit_odd,
  output logic [XLEN-1:0]      IBuff_out,
  output logic [XLEN-1:0]      pc_out,
  output logic                 valid_out
);

  localparam int unsigned OffBits  = $clog2(CL_SIZE / 8);
  localparam int unsigned WordBits = OffBits - 2;
  localparam int unsigned RasDepth = 8;

  // ---------------------------------------------------------------- C stage
  logic [XLEN-1:0]      pc_q, pc_d;
  logic [CLC_WIDTH-1:0] line, line_inc;
  logic                 ras_redirect, redirect, flush, fe_hold;

  logic [XLEN-1:0] ras_q [RasDepth];
  logic [2:0]      ras_top_q;
  logic [3:0]      ras_cnt_q;

  assign ras_valid_out = (ras_cnt_q != 4'd0);
  assign ras_data_out  = ras_q[ras_top_q];

  assign ras_redirect = ras_pop & ras_valid_out;
  assign redirect     = resteer_taken_ROB | resteer_taken_BR | resteer_taken_D1 | ras_redirect;
  assign flush        = redirect | resteer;
  assign fe_hold      = stall_in | mem_stall;

  always_comb begin
    pc_d = pc_q + XLEN'(4);
    if (resteer_taken_ROB) begin
      pc_d = {resteer_target_ROB[XLEN-1:2], 2'b00};
    end else if (resteer_taken_BR) begin
      pc_d = {resteer_target_BR[XLEN-1:2], 2'b00};
    end else if (resteer_taken_D1) begin
      pc_d = {resteer_target_D1[XLEN-1:2], 2'b00};
    end else if (ras_redirect) begin
      pc_d = {ras_data_out[XLEN-1:2], 2'b00};
    end else if (resteer || fe_hold) begin
      // A bare resteer refetches from the current PC.
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  assign line     = pc_q[XLEN-1:OffBits];
  assign line_inc = line + CLC_WIDTH'(1);

  always_comb begin
    clc_even = line;
    clc_odd  = line_inc;
    if (line[0]) begin
      clc_even = line_inc;
      clc_odd  = line;
    end
  end

  // Circular return stack: push on full overwrites the oldest entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RasDepth; i++) ras_q[i] <= '0;
      ras_top_q <= '0;
      ras_cnt_q <= '0;
    end else if (ras_push && ras_pop && ras_valid_out) begin
      ras_q[ras_top_q] <= ras_ret_addr;
    end else if (ras_push) begin
      ras_q[ras_top_q + 3'd1] <= ras_ret_addr;
      ras_top_q               <= ras_top_q + 3'd1;
      if (ras_cnt_q != 4'(RasDepth)) ras_cnt_q <= ras_cnt_q + 4'd1;
    end else if (ras_pop && ras_valid_out) begin
      ras_top_q <= ras_top_q - 3'd1;
      ras_cnt_q <= ras_cnt_q - 4'd1;
    end
  end

  // --------------------------------------------------------------- F1 stage
  logic [XLEN-1:0] f1_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f1_pc_q         <= '0;
      addr_even       <= '0;
      addr_odd        <= '0;
      addr_even_valid <= 1'b0;
      addr_odd_valid  <= 1'b0;
    end else if (flush) begin
      addr_even_valid <= 1'b0;
      addr_odd_valid  <= 1'b0;
    end else if (!fe_hold) begin
      f1_pc_q         <= pc_q;
      addr_even       <= {clc_even, OffBits'(0)};
      addr_odd        <= {clc_odd, OffBits'(0)};
      addr_even_valid <= 1'b1;
      addr_odd_valid  <= 1'b1;
    end
  end

  // --------------------------------------------------------------- F2 stage
  logic                odd_sel, sel_hit, sel_valid;
  logic [CL_SIZE-1:0]  sel_line, shifted;
  logic [WordBits-1:0] word_idx;

  assign odd_sel   = f1_pc_q[OffBits];
  assign sel_line  = odd_sel ? cl_odd : cl_even;
  assign sel_hit   = odd_sel ? hit_odd : hit_even;
  assign sel_valid = odd_sel ? addr_odd_valid : addr_even_valid;
  assign word_idx  = f1_pc_q[OffBits-1:2];
  assign shifted   = sel_line >> {word_idx, 5'd0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      IBuff_out <= '0;
      pc_out    <= '0;
      valid_out <= 1'b0;
    end else if (flush) begin
      valid_out <= 1'b0;
    end else if (!stall_in) begin
      IBuff_out <= shifted[XLEN-1:0];
      pc_out    <= f1_pc_q;
      valid_out <= sel_valid & sel_hit & ~mem_stall;
    end
  end

endmodule

// File: tb/tb_fetch_front.sv
// Directed bench for fetch_front; the cache model returns (word address ^ 0x13) per word,
// so every expected instruction is pc ^ 0x13.
module tb_fetch_front;
  localparam int unsigned XLEN = 32, CL_SIZE = 128, CLC_WIDTH = 28;

  logic clk = 1'b0, rst = 1'b1;
  logic stall_in, mem_stall, resteer;
  logic rob_t, br_t, d1_t;
  logic [XLEN-1:0] rob_tgt, br_tgt, d1_tgt;
  logic ras_push, ras_pop;
  logic [XLEN-1:0] ras_ret_addr;
  logic [CLC_WIDTH-1:0] clc_even, clc_odd;
  logic [XLEN-1:0] ras_data_out, addr_even, addr_odd, IBuff_out, pc_out;
  logic ras_valid_out, addr_even_valid, addr_odd_valid, valid_out;
  logic [CL_SIZE-1:0] cl_even, cl_odd;
  logic hit_even, hit_odd;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  fetch_front #(.XLEN(XLEN), .CL_SIZE(CL_SIZE), .CLC_WIDTH(CLC_WIDTH)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .mem_stall(mem_stall), .resteer(resteer),
    .resteer_taken_ROB(rob_t), .resteer_target_ROB(rob_tgt),
    .resteer_taken_BR(br_t), .resteer_target_BR(br_tgt),
    .resteer_taken_D1(d1_t), .resteer_target_D1(d1_tgt),
    .ras_push(ras_push), .ras_pop(ras_pop), .ras_ret_addr(ras_ret_addr),
    .clc_even(clc_even), .clc_odd(clc_odd), .ras_data_out(ras_data_out),
    .ras_valid_out(ras_valid_out), .addr_even(addr_even), .addr_odd(addr_odd),
    .addr_even_valid(addr_even_valid), .addr_odd_valid(addr_odd_valid),
    .cl_even(cl_even), .cl_odd(cl_odd), .hit_even(hit_even), .hit_odd(hit_odd),
    .IBuff_out(IBuff_out), .pc_out(pc_out), .valid_out(valid_out)
  );

  always_comb begin
    cl_even = '0;
    cl_odd  = '0;
    for (int i = 0; i < 4; i++) begin
      cl_even[32*i +: 32] = (addr_even + 32'(4 * i)) ^ 32'h13;
      cl_odd[32*i +: 32]  = (addr_odd + 32'(4 * i)) ^ 32'h13;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stall_in = 0; mem_stall = 0; resteer = 0;
    rob_t = 0; br_t = 0; d1_t = 0; rob_tgt = 0; br_tgt = 0; d1_tgt = 0;
    ras_push = 0; ras_pop = 0; ras_ret_addr = 0; hit_even = 1; hit_odd = 1;
    rst = 1;
    #2;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid_out); end
    checks++; if (IBuff_out !== 32'h0 || pc_out !== 32'h0) begin failures++; $display("FAIL rst_f2 got=%h/%h exp=0/0", IBuff_out, pc_out); end
    checks++; if (addr_even_valid !== 1'b0 || addr_odd_valid !== 1'b0) begin failures++; $display("FAIL rst_f1v got=%b%b exp=00", addr_even_valid, addr_odd_valid); end
    checks++; if (clc_even !== 28'h0 || clc_odd !== 28'h1) begin failures++; $display("FAIL rst_clc got=%h/%h exp=0/1", clc_even, clc_odd); end
    checks++; if (ras_valid_out !== 1'b0) begin failures++; $display("FAIL rst_ras got=%b exp=0", ras_valid_out); end
    step();
    checks++; if (valid_out !== 1'b0 || addr_even_valid !== 1'b1) begin failures++; $display("FAIL c1 got=%b/%b exp=0/1", valid_out, addr_even_valid); end
    step();
    checks++; if (valid_out !== 1'b1 || IBuff_out !== 32'h13 || pc_out !== 32'h0) begin failures++; $display("FAIL c2 got=%b %h %h exp=1 00000013 0", valid_out, IBuff_out, pc_out); end
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++; if (valid_out !== 1'b1 || pc_out !== 32'(4 * k) || IBuff_out !== (32'(4 * k) ^ 32'h13)) begin failures++; $display("FAIL seq%0d got=%b %h %h", k, valid_out, pc_out, IBuff_out); end
    end
  endtask

  task automatic test_odd_line();
    do_reset();
    repeat (4) step();  // pc = 0x10
    checks++; if (clc_odd !== 28'h1 || clc_even !== 28'h2) begin failures++; $display("FAIL odd_clc got=%h/%h exp=1/2", clc_odd, clc_even); end
    step();
    checks++; if (addr_odd !== 32'h10 || addr_even !== 32'h20) begin failures++; $display("FAIL odd_addr got=%h/%h exp=10/20", addr_odd, addr_even); end
    step();
    checks++; if (pc_out !== 32'h10 || IBuff_out !== 32'h03 || valid_out !== 1'b1) begin failures++; $display("FAIL odd_sel got=%h %h %b exp=10 03 1", pc_out, IBuff_out, valid_out); end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (2) step();
    rob_t = 1; rob_tgt = 32'h200; br_t = 1; br_tgt = 32'h100;
    step();
    rob_t = 0; br_t = 0;
    checks++; if (clc_even !== 28'h20 || clc_odd !== 28'h21 || valid_out !== 1'b0) begin failures++; $display("FAIL rob_pc got=%h/%h %b exp=20/21 0", clc_even, clc_odd, valid_out); end
    step();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rob_bub got=%b exp=0", valid_out); end
    step();
    checks++; if (valid_out !== 1'b1 || pc_out !== 32'h200 || IBuff_out !== 32'h213) begin failures++; $display("FAIL rob_out got=%b %h %h exp=1 200 213", valid_out, pc_out, IBuff_out); end
    d1_t = 1; d1_tgt = 32'h313;
    step();
    d1_t = 0;
    checks++; if (clc_odd !== 28'h31 || clc_even !== 28'h32 || addr_even_valid !== 1'b0) begin failures++; $display("FAIL d1 got=%h/%h %b exp=31/32 0", clc_odd, clc_even, addr_even_valid); end
    repeat (2) step();
    checks++; if (pc_out !== 32'h310 || valid_out !== 1'b1) begin failures++; $display("FAIL d1_out got=%h %b exp=310 1", pc_out, valid_out); end
  endtask

  task automatic test_stalls();
    do_reset();
    repeat (3) step();  // pc=0xC, F1=0x8, F2=0x4
    stall_in = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (pc_out !== 32'h4 || valid_out !== 1'b1 || addr_odd !== 32'h10 || clc_odd !== 28'h1 || clc_even !== 28'h0) begin failures++; $display("FAIL stall%0d got=%h %b %h %h", k, pc_out, valid_out, addr_odd, clc_even); end
    end
    stall_in = 0;
    step();
    checks++; if (pc_out !== 32'h8 || valid_out !== 1'b1) begin failures++; $display("FAIL unstall got=%h %b exp=8 1", pc_out, valid_out); end
    mem_stall = 1;  // pc=0x10, F1=0xC
    repeat (2) step();
    checks++; if (valid_out !== 1'b0 || clc_odd !== 28'h1 || clc_even !== 28'h2 || addr_odd !== 32'h10 || addr_even !== 32'h0) begin failures++; $display("FAIL mstall got=%b %h %h %h", valid_out, clc_odd, addr_odd, addr_even); end
    mem_stall = 0;
    step();
    checks++; if (valid_out !== 1'b1 || pc_out !== 32'hC || IBuff_out !== 32'h1F) begin failures++; $display("FAIL mresume got=%b %h %h exp=1 c 1f", valid_out, pc_out, IBuff_out); end
    step();
    checks++; if (pc_out !== 32'h10) begin failures++; $display("FAIL mnext got=%h exp=10", pc_out); end
  endtask

  task automatic test_resteer();
    do_reset();
    repeat (3) step();  // pc=0xC
    resteer = 1;
    step();
    resteer = 0;
    checks++; if (valid_out !== 1'b0 || addr_even_valid !== 1'b0 || addr_odd_valid !== 1'b0) begin failures++; $display("FAIL rs_flush got=%b %b%b exp=0 00", valid_out, addr_even_valid, addr_odd_valid); end
    repeat (2) step();
    checks++; if (pc_out !== 32'hC || valid_out !== 1'b1) begin failures++; $display("FAIL rs_pc got=%h %b exp=c 1", pc_out, valid_out); end
  endtask

  task automatic test_ras();
    do_reset();
    ras_push = 1; ras_ret_addr = 32'hA0; step();
    ras_ret_addr = 32'hB0; step();
    ras_push = 0;
    checks++; if (ras_data_out !== 32'hB0 || ras_valid_out !== 1'b1) begin failures++; $display("FAIL ras_top got=%h %b exp=b0 1", ras_data_out, ras_valid_out); end
    ras_pop = 1; step(); ras_pop = 0;
    checks++; if (ras_data_out !== 32'hA0 || clc_odd !== 28'hB || clc_even !== 28'hC || valid_out !== 1'b0) begin failures++; $display("FAIL ras_pop got=%h %h %h %b", ras_data_out, clc_odd, clc_even, valid_out); end
    ras_pop = 1; step();  // redirect to 0xA0, stack now empty
    checks++; if (ras_valid_out !== 1'b0 || clc_even !== 28'hA) begin failures++; $display("FAIL ras_pop2 got=%b %h exp=0 a", ras_valid_out, clc_even); end
    step(); ras_pop = 0;  // pop on empty must not flush
    checks++; if (addr_even_valid !== 1'b1 || addr_even !== 32'hA0) begin failures++; $display("FAIL ras_empty got=%b %h exp=1 a0", addr_even_valid, addr_even); end
    step();
    checks++; if (valid_out !== 1'b1 || pc_out !== 32'hA0) begin failures++; $display("FAIL ras_empty_out got=%b %h exp=1 a0", valid_out, pc_out); end
    ras_push = 1;
    for (int k = 1; k <= 9; k++) begin ras_ret_addr = 32'(k * 16); step(); end
    ras_push = 0;
    checks++; if (ras_data_out !== 32'h90) begin failures++; $display("FAIL ras9 got=%h exp=90", ras_data_out); end
    ras_pop = 1;
    repeat (7) step();
    checks++; if (ras_data_out !== 32'h20 || ras_valid_out !== 1'b1) begin failures++; $display("FAIL ras_old got=%h %b exp=20 1", ras_data_out, ras_valid_out); end
    step(); ras_pop = 0;
    checks++; if (ras_valid_out !== 1'b0) begin failures++; $display("FAIL ras_lost got=%b exp=0", ras_valid_out); end
  endtask

  task automatic test_miss();
    do_reset();
    hit_even = 0;
    repeat (2) step();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL miss got=%b exp=0", valid_out); end
    hit_even = 1; hit_odd = 0;
    step();
    checks++; if (valid_out !== 1'b1 || pc_out !== 32'h4) begin failures++; $display("FAIL miss_odd_ok got=%b %h exp=1 4", valid_out, pc_out); end
  endtask

  initial begin
    test_reset();
    test_odd_line();
    test_redirect();
    test_stalls();
    test_resteer();
    test_ras();
    test_miss();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
